// File: rtl/pl_ex_mem_stage_pkg.sv
// Shared widths and control-bit payload type for the EX/MEM pipeline register.
package pl_ex_mem_stage_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned RA_W_DEF        = 2;
    localparam int unsigned STALL_CNT_W_DEF = 16;

    // MEM and WB control bits carried alongside the data payload.
    typedef struct packed {
        logic mem_wr_en;
        logic mem_imm_sel;
        logic wb_wb_sel;
        logic wb_reg_en;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pl_ex_mem_stage_if.sv
// Valid/ready instruction bus between pipeline stages (EX->stage, stage->MEM).
interface pl_ex_mem_stage_if
    import pl_ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RA_W   = RA_W_DEF
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] alu;
    logic [RA_W-1:0]   ra;
    logic [DATA_W-1:0] ea;
    logic              mem_wr_en;
    logic              mem_imm_sel;
    logic              wb_wb_sel;
    logic              wb_reg_en;

    modport master (
        output valid, alu, ra, ea, mem_wr_en, mem_imm_sel, wb_wb_sel, wb_reg_en,
        input  ready
    );

    modport slave (
        input  valid, alu, ra, ea, mem_wr_en, mem_imm_sel, wb_wb_sel, wb_reg_en,
        output ready
    );

endinterface

// File: rtl/pl_ex_mem_stage_reg.sv
// pl_stage_reg: one payload register plus valid bit; clear drops valid but keeps the payload.
module pl_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // clear wins over load so a flush always kills the entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pl_ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush and saturating stall counter.
// Optional one-entry skid buffer enabled by defining PL_EX_MEM_SKID_EN.
module pl_ex_mem_stage
    import pl_ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RA_W        = RA_W_DEF,
    parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pl_ex_mem_stage_if.slave       ex,
    pl_ex_mem_stage_if.master      mem,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int unsigned PAY_W = DATA_W + RA_W + DATA_W + CTRL_W;

    ctrl_t             in_ctrl;
    ctrl_t             out_ctrl;
    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  o_d;
    logic [PAY_W-1:0]  o_q;
    logic              o_v;
    logic              o_load;
    logic              o_clr;
    logic              in_rdy;
    logic              accept;
    logic              drain;
    logic              stalled;

    assign in_ctrl = {ex.mem_wr_en, ex.mem_imm_sel, ex.wb_wb_sel, ex.wb_reg_en};
    assign in_pay  = {ex.alu, ex.ra, ex.ea, in_ctrl};
    assign ex.ready = in_rdy;

    // flush kills anything presented on the same edge
    assign accept  = ex.valid && in_rdy && !flush;
    assign drain   = o_v && mem.ready;
    assign stalled = o_v && !mem.ready;

`ifdef PL_EX_MEM_SKID_EN
    logic             s_v;
    logic [PAY_W-1:0] s_q;
    logic             s_load;
    logic             s_clr;

    // ready comes straight from the skid valid flop
    assign in_rdy = !s_v;

    // skid entry always drains first to keep delivery in order
    always_comb begin
        o_load = 1'b0;
        o_clr  = 1'b0;
        s_load = 1'b0;
        s_clr  = 1'b0;
        o_d    = in_pay;
        if (flush) begin
            o_clr = 1'b1;
            s_clr = 1'b1;
        end else if (s_v) begin
            if (drain) begin
                o_load = 1'b1;
                o_d    = s_q;
                s_clr  = 1'b1;
            end
        end else if (accept) begin
            if (!o_v || drain) begin
                o_load = 1'b1;
            end else begin
                s_load = 1'b1;
            end
        end else if (drain) begin
            o_clr = 1'b1;
        end
    end

    pl_stage_reg #(
        .W (PAY_W)
    ) u_skid_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clr),
        .d     (in_pay),
        .valid (s_v),
        .q     (s_q)
    );
`else
    assign in_rdy = !o_v || mem.ready;

    always_comb begin
        o_load = 1'b0;
        o_clr  = 1'b0;
        o_d    = in_pay;
        if (flush) begin
            o_clr = 1'b1;
        end else if (accept) begin
            o_load = 1'b1;
        end else if (drain) begin
            o_clr = 1'b1;
        end
    end
`endif

    pl_stage_reg #(
        .W (PAY_W)
    ) u_out_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (o_load),
        .clear (o_clr),
        .d     (o_d),
        .valid (o_v),
        .q     (o_q)
    );

    assign {mem.alu, mem.ra, mem.ea, out_ctrl} = o_q;
    assign mem.valid = o_v;

    // side-effecting controls read as a bubble whenever nothing is presented
    assign mem.mem_wr_en   = out_ctrl.mem_wr_en & o_v;
    assign mem.wb_reg_en   = out_ctrl.wb_reg_en & o_v;
    assign mem.mem_imm_sel = out_ctrl.mem_imm_sel;
    assign mem.wb_wb_sel   = out_ctrl.wb_wb_sel;

    // saturating count of back-pressured cycles; survives flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pl_ex_mem_stage.sv
// Directed self-checking bench for pl_ex_mem_stage (wide data, 4-bit stall counter).
module tb_pl_ex_mem_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [SW-1:0] stall_cnt;
    int            n_checks = 0;
    int            n_errors = 0;

    pl_ex_mem_stage_if #(.DATA_W(DW), .RA_W(RW)) ex_bus ();
    pl_ex_mem_stage_if #(.DATA_W(DW), .RA_W(RW)) mem_bus ();

    pl_ex_mem_stage #(
        .DATA_W      (DW),
        .RA_W        (RW),
        .STALL_CNT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ex        (ex_bus),
        .mem       (mem_bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // c = {mem_wr_en, mem_imm_sel, wb_wb_sel, wb_reg_en}
    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [RW-1:0] r,
                         input logic [DW-1:0] e, input logic [3:0] c);
        ex_bus.valid = v;
        ex_bus.alu   = a;
        ex_bus.ra    = r;
        ex_bus.ea    = e;
        {ex_bus.mem_wr_en, ex_bus.mem_imm_sel, ex_bus.wb_wb_sel, ex_bus.wb_reg_en} = c;
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        mem_bus.ready = 1'b1;
        drive(1'b0, '0, '0, '0, 4'h0);
        repeat (2) @(negedge clk);

        check("rst_valid", mem_bus.valid, 0);
        check("rst_alu", mem_bus.alu, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_ready", ex_bus.ready, 1);
        check("rst_wr_en", mem_bus.mem_wr_en, 0);
        #2 rst = 1'b1;
        @(negedge clk);

        // back-to-back stream, one cycle of latency
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(32'h11 + i), RW'(i), DW'(32'h80 + i), 4'hF);
            @(negedge clk);
            check("stream_valid", mem_bus.valid, 1);
            check("stream_alu", mem_bus.alu, 64'h11 + 64'(i));
        end
        check("stream_ra", mem_bus.ra, 4);
        check("stream_ea", mem_bus.ea, 32'h84);

        drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0);
        @(negedge clk);
        check("bubble_valid", mem_bus.valid, 0);
        check("bubble_wr_en", mem_bus.mem_wr_en, 0);
        check("bubble_reg_en", mem_bus.wb_reg_en, 0);
        check("bubble_imm_keep", mem_bus.mem_imm_sel, 1);
        check("bubble_alu_keep", mem_bus.alu, 32'h15);

        // back-pressure for five cycles
        drive(1'b1, 32'h21, 5'd3, 32'h44, 4'b0110);
        @(negedge clk);
        check("stall_cap_alu", mem_bus.alu, 32'h21);
        mem_bus.ready = 1'b0;
        drive(1'b1, 32'h22, 5'd4, 32'h45, 4'b0110);
        repeat (5) @(negedge clk);
        check("stall_valid", mem_bus.valid, 1);
        check("stall_alu", mem_bus.alu, 32'h21);
        check("stall_ra", mem_bus.ra, 3);
        check("stall_ea", mem_bus.ea, 32'h44);
        check("stall_wbsel", mem_bus.wb_wb_sel, 1);
        check("stall_cnt5", stall_cnt, 5);
        check("stall_ready", ex_bus.ready, 0);

        // release: 0x22 follows immediately (capture and drain together)
        mem_bus.ready = 1'b1;
        @(negedge clk);
        check("drain_valid", mem_bus.valid, 1);
        check("drain_alu", mem_bus.alu, 32'h22);
        check("drain_ra", mem_bus.ra, 4);
        check("drain_cnt", stall_cnt, 5);
        drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0);
        @(negedge clk);
        check("empty_valid", mem_bus.valid, 0);

        // flush beats a simultaneous capture
        drive(1'b1, 32'h33, 5'd1, 32'h50, 4'b0001);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_cap_valid", mem_bus.valid, 0);
        check("flush_cap_reg_en", mem_bus.wb_reg_en, 0);
        check("flush_cap_alu", mem_bus.alu, 32'h22);

        // flush a held, stalled word; counter survives
        drive(1'b1, 32'h34, 5'd2, 32'h51, 4'b0001);
        mem_bus.ready = 1'b0;
        @(negedge clk);
        check("hold_valid", mem_bus.valid, 1);
        check("hold_alu", mem_bus.alu, 32'h34);
        check("hold_reg_en", mem_bus.wb_reg_en, 1);
        drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_hold_valid", mem_bus.valid, 0);
        check("flush_keep_cnt", stall_cnt, 6);

        // full-width payload, then long stall to saturate
        drive(1'b1, 32'hDEADBEEF, 5'd31, 32'h12345678, 4'b1010);
        @(negedge clk);
        check("wide_valid", mem_bus.valid, 1);
        check("wide_alu", mem_bus.alu, 32'hDEADBEEF);
        check("wide_ra", mem_bus.ra, 31);
        check("wide_ea", mem_bus.ea, 32'h12345678);
        check("wide_ctrl", {mem_bus.mem_wr_en, mem_bus.mem_imm_sel,
                            mem_bus.wb_wb_sel, mem_bus.wb_reg_en}, 4'b1010);
        check("wide_cnt", stall_cnt, 6);
        drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0);
        repeat (20) @(negedge clk);
        check("sat_cnt", stall_cnt, 15);
        check("sat_alu", mem_bus.alu, 32'hDEADBEEF);

        // asynchronous reset between edges
        drive(1'b1, 32'h66, 5'd6, 32'h60, 4'b1001);
        mem_bus.ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", mem_bus.valid, 0);
        check("arst_alu", mem_bus.alu, 0);
        check("arst_ra", mem_bus.ra, 0);
        check("arst_ea", mem_bus.ea, 0);
        check("arst_cnt", stall_cnt, 0);
        check("arst_ready", ex_bus.ready, 1);
        drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", mem_bus.valid, 0);
        check("post_rst_wr_en", mem_bus.mem_wr_en, 0);
        drive(1'b1, 32'h77, 5'd5, 32'h99, 4'b1000);
        @(negedge clk);
        check("post_rst_cap_valid", mem_bus.valid, 1);
        check("post_rst_cap_alu", mem_bus.alu, 32'h77);
        check("post_rst_cap_wr_en", mem_bus.mem_wr_en, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pl_ex_mem_stage.md
PL_EX_MEM_STAGE -- requirements
Module: pl_ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 8, ALU result and effective-address width.
REQ-002 Parameter RA_W, default 2, register-address width.
REQ-003 Parameter STALL_CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 in_valid  input  1  the EX stage presents an instruction.
REQ-007 in_ready  output  1  the stage accepts the instruction this cycle.
REQ-008 alu  input  DATA_W  ALU result.
REQ-009 ra  input  RA_W  destination register address.
REQ-010 ea  input  DATA_W  effective address.
REQ-011 mem_wr_en, mem_imm_sel, wb_wb_sel, wb_reg_en  input  1 each  MEM and WB controls.
REQ-012 flush  input  1  kills every held instruction.
REQ-013 out_valid  output  1  the MEM stage is presented an instruction.
REQ-014 out_ready  input  1  the MEM stage accepts it.
REQ-015 alu_out, ra_out, ea_out  output  DATA_W/RA_W/DATA_W  registered copies of the inputs.
REQ-016 mem_wr_en_out, mem_imm_sel_out, wb_wb_sel_out, wb_reg_en_out  output  1 each  registered controls.
REQ-017 stall_cnt  output  STALL_CNT_W  count of stalled cycles.

Function
REQ-018 The stage SHALL capture all payload and control inputs on a clock edge where in_valid && in_ready && !flush.
REQ-019 Without skid, in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-020 On each edge, out_valid SHALL be set on capture, else cleared when out_ready = 1, else held.
REQ-021 Latency from capture to out_valid SHALL be exactly 1 cycle.
REQ-022 While out_valid = 0, mem_wr_en_out and wb_reg_en_out SHALL read 0 (bubble); other outputs keep their last value.
REQ-023 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-024 flush SHALL clear out_valid (and the skid entry) on the next edge; flush beats a simultaneous capture.
REQ-025 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready.
REQ-026 stall_cnt SHALL saturate at all-ones and never wrap.
REQ-027 flush SHALL NOT clear stall_cnt.
REQ-028 Simultaneous capture and drain SHALL keep out_valid = 1, with the new payload.

Reset
REQ-029 While rst = 0, out_valid, the skid entry, all data/control outputs and stall_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 in_ready SHALL read 1 during reset when the skid buffer is compiled in, and follow REQ-019 otherwise.
REQ-031 An instruction in flight at reset assertion SHALL be discarded; no output pulses on deassertion.

Configuration
REQ-032 Macro PL_EX_MEM_SKID_EN, when defined, SHALL add one skid entry.
REQ-033 With the skid entry, in_ready SHALL be registered and equal !skid_valid.
REQ-034 With the skid entry, a capture while outputs are stalled SHALL go to the skid entry.
REQ-035 With the skid entry, a drain SHALL move the skid entry to the outputs with no lost cycle.
REQ-036 With the skid entry, in-order delivery SHALL be kept and capacity is 2.
REQ-037 Undefined, the stage SHALL behave per REQ-019 with capacity 1.

Structure
REQ-038 A shared package SHALL hold the default widths and a packed struct of the four control bits (mem_wr_en, mem_imm_sel, wb_wb_sel, wb_reg_en).
REQ-039 Sub-module pl_stage_reg (one payload-plus-valid register with load/clear/hold) SHALL be used for the output entry and the skid entry.

Verification
REQ-040 After reset, stream alu=0x11..0x15 with out_ready=1 -> alu_out shows 0x11..0x15 on consecutive cycles, one cycle late, out_valid=1 continuously.
REQ-041 Hold out_ready=0 for 5 cycles with out_valid=1 -> outputs stable, stall_cnt=5, in_ready=0 (no skid) or one extra word accepted (skid).
REQ-042 Assert flush together with in_valid=1 and wb_reg_en=1 -> next cycle out_valid=0 and wb_reg_en_out=0.
REQ-043 STALL_CNT_W=4, stall 20 cycles -> stall_cnt stays at 15.
REQ-044 Pull rst low mid-stream between edges -> all outputs 0 at once; after release, out_valid=0 until the next capture.
REQ-045 DATA_W=32, RA_W=5, alu=0xDEADBEEF, ra=31 -> outputs match bit-exactly.
